// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan display driver.
//   SEG_A..SEG_DP : bit positions inside the {dp,g,f,e,d,c,b,a} segment bus
//   HEX_GLYPH     : active-high g..a patterns for hex digits 0..F
//   MAX_DIGITS    : largest supported number of digit positions
package sseg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/sseg_hex_decoder.sv
// Combinational hex-to-seven-segment decoder, active-high output.
// Polarity inversion for the board pins is done by the caller.
//   i_nibble : hex digit 0..F
//   i_dp     : decimal point request
//   o_seg    : {dp,g,f,e,d,c,b,a}, 1 = segment lit
module sseg_hex_decoder
  import sseg_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg              = 8'h00;
    o_seg[SEG_G:SEG_A] = HEX_GLYPH[i_nibble];
    o_seg[SEG_DP]      = i_dp;
  end

endmodule

// File: rtl/sseg_scan_display.sv
// Time-multiplexed hex display driver. One digit is lit per refresh slot;
// the first cycle of each slot is a blank guard to stop ghosting between
// digits. Loaded values are parked in a pending buffer and only move into
// the displayed (shadow) value at a frame wrap, so a frame never mixes old
// and new digits.
//
// Optional build macro:
//   SSEG_LEADING_ZERO_BLANK_EN - blank segments of digits above the highest
//                                nonzero nibble (digit 0 always shown).
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   value, load     : value to show and its single-cycle capture strobe
//   dp              : per-digit decimal point, sampled live
//   enable          : 0 blanks the display and parks the scan at digit 0
//   sseg_indicator  : registered segment bus {dp,g,f,e,d,c,b,a}
//   digits          : registered one-hot digit enable
//   frame_done      : high on the last cycle of each full scan
module sseg_scan_display
  import sseg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int VALUE_W     = 16,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  input  logic [DIGITS-1:0]  dp,
  input  logic               enable,
  output logic [7:0]         sseg_indicator,
  output logic [DIGITS-1:0]  digits,
  output logic               frame_done
);

  localparam int SH_W  = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW    = $clog2(REFRESH_DIV);

  localparam logic [PW-1:0]     PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [7:0]        SEG_OFF    = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] DIG_OFF    = (ACTIVE_LOW != 0) ? '1 : '0;

  if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("sseg_scan_display: DIGITS out of range");
  end
  if (VALUE_W > SH_W) begin : g_bad_width
    $error("sseg_scan_display: VALUE_W exceeds 4*DIGITS");
  end
  if (REFRESH_DIV < 2) begin : g_bad_div
    $error("sseg_scan_display: REFRESH_DIV must be at least 2");
  end

  logic [PW-1:0]     r_presc;
  logic [IDX_W-1:0]  r_idx;
  logic [SH_W-1:0]   r_pending;
  logic              r_pending_valid;
  logic [SH_W-1:0]   r_shadow;
  logic [7:0]        r_sseg;
  logic [DIGITS-1:0] r_digits;

  logic              w_slot_end;
  logic              w_wrap;
  logic [SH_W-1:0]   w_value_ext;
  logic [3:0]        w_nibble;
  logic              w_dp;
  logic [7:0]        w_seg_hi;
  logic              w_lz_blank;
  logic [7:0]        w_seg_masked;
  logic [7:0]        w_seg_drive;
  logic [DIGITS-1:0] w_dig_hot;
  logic [DIGITS-1:0] w_dig_drive;

  assign w_slot_end  = (r_presc == PRESC_LAST);
  assign w_wrap      = w_slot_end && (r_idx == IDX_LAST);
  assign w_value_ext = SH_W'(value);
  assign w_nibble    = r_shadow[{r_idx, 2'b00} +: 4];
  assign w_dp        = dp[r_idx];

  sseg_hex_decoder u_hex_decoder (
    .i_nibble (w_nibble),
    .i_dp     (w_dp),
    .o_seg    (w_seg_hi)
  );

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every nibble above it are zero.
  assign w_lz_blank = (r_idx != '0) && ((r_shadow >> {r_idx, 2'b00}) == '0);
`else
  assign w_lz_blank = 1'b0;
`endif

  assign w_seg_masked = w_lz_blank ? {w_seg_hi[SEG_DP], 7'b0} : w_seg_hi;
  assign w_seg_drive  = (ACTIVE_LOW != 0) ? ~w_seg_masked : w_seg_masked;
  assign w_dig_hot    = DIGITS'(1) << r_idx;
  assign w_dig_drive  = (ACTIVE_LOW != 0) ? ~w_dig_hot : w_dig_hot;

  assign frame_done = enable && !reset && w_wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc         <= '0;
      r_idx           <= '0;
      r_pending       <= '0;
      r_pending_valid <= 1'b0;
      r_shadow        <= '0;
      r_sseg          <= SEG_OFF;
      r_digits        <= DIG_OFF;
    end else if (!enable) begin
      r_presc  <= '0;
      r_idx    <= '0;
      r_sseg   <= SEG_OFF;
      r_digits <= DIG_OFF;
      // Nothing is being scanned, so a load can go straight to display.
      if (load) begin
        r_shadow        <= w_value_ext;
        r_pending_valid <= 1'b0;
      end
    end else begin
      if (w_slot_end) begin
        r_presc <= '0;
        r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end

      // A load landing on the wrap itself beats any older pending value.
      if (w_wrap) begin
        if (load) begin
          r_shadow <= w_value_ext;
        end else if (r_pending_valid) begin
          r_shadow <= r_pending;
        end
        r_pending_valid <= 1'b0;
      end else if (load) begin
        r_pending       <= w_value_ext;
        r_pending_valid <= 1'b1;
      end

      if (r_presc == '0) begin
        r_sseg   <= SEG_OFF;
        r_digits <= DIG_OFF;
      end else begin
        r_sseg   <= w_seg_drive;
        r_digits <= w_dig_drive;
      end
    end
  end

  assign sseg_indicator = r_sseg;
  assign digits         = r_digits;

endmodule

// File: tb/tb_sseg_scan_display.sv
module tb_sseg_scan_display;

  localparam int D  = 4;
  localparam int RD = 4;
  localparam int FRAME = D * RD;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp;
  logic        enable;
  logic [7:0]  sseg_indicator;
  logic [3:0]  digits;
  logic        frame_done;

  always #5 clk = ~clk;

  sseg_scan_display #(
    .DIGITS      (D),
    .VALUE_W     (16),
    .REFRESH_DIV (RD),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .value          (value),
    .load           (load),
    .dp             (dp),
    .enable         (enable),
    .sseg_indicator (sseg_indicator),
    .digits         (digits),
    .frame_done     (frame_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: frame position counter plus the buffered values.
  // Evaluated on the falling edge, predicting what the next rising edge does.
  logic [7:0]  glyph [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                              8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  int          m_pos = 0;
  logic [15:0] m_shadow = '0;
  logic [15:0] m_pending = '0;
  bit          m_pv = 0;
  logic [7:0]  m_seg = 8'hFF;
  logic [3:0]  m_dig = 4'hF;
  bit          m_started = 0;

  always @(negedge clk) begin
    bit         fd_exp;
    int         slot;
    int         cyc;
    int         nib;
    logic [7:0] pat;
    fd_exp = !reset && enable && (m_pos == FRAME - 1);
    if (m_started) begin
      check("model_seg", sseg_indicator, m_seg);
      check("model_digits", digits, m_dig);
      check("model_frame_done", frame_done, fd_exp);
    end
    if (reset) begin
      m_pos = 0; m_shadow = '0; m_pending = '0; m_pv = 0;
      m_seg = 8'hFF; m_dig = 4'hF;
    end else if (!enable) begin
      m_pos = 0;
      m_seg = 8'hFF; m_dig = 4'hF;
      if (load) begin
        m_shadow = value;
        m_pv = 0;
      end
    end else begin
      slot = m_pos / RD;
      cyc  = m_pos % RD;
      if (cyc == 0) begin
        m_seg = 8'hFF; m_dig = 4'hF;
      end else begin
        nib = int'((m_shadow >> (4 * slot)) & 16'hF);
        pat = glyph[nib];
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        if (slot > 0 && (m_shadow >> (4 * slot)) == 16'h0) pat = 8'h00;
`endif
        pat[7] = dp[slot];
        m_seg = ~pat;
        m_dig = ~(4'b0001 << slot);
      end
      if (m_pos == FRAME - 1) begin
        if (load) m_shadow = value;
        else if (m_pv) m_shadow = m_pending;
        m_pv = 0;
      end else if (load) begin
        m_pending = value;
        m_pv = 1;
      end
      m_pos = (m_pos + 1) % FRAME;
    end
    m_started = 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_digit(input logic [3:0] pat, input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (digits == pat) seen = 1;
    end
    check(name, {31'b0, seen}, 32'd1);
  endtask

  initial begin
    bit seen;
    reset = 1'b1; enable = 1'b0; load = 1'b0; dp = '0; value = '0;

    repeat (3) begin
      tick();
      check("reset_seg", sseg_indicator, 8'hFF);
      check("reset_digits", digits, 4'hF);
      check("reset_fd", frame_done, 1'b0);
    end
    reset = 1'b0;

    // Basic scan of 12AF, loaded while disabled so it is shown at once.
    value = 16'h12AF; load = 1'b1;
    tick();
    load = 1'b0; enable = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k == 0) begin
        check("scan_guard_seg", sseg_indicator, 8'hFF);
        check("scan_guard_dig", digits, 4'hF);
      end
      if (k == 1) begin
        check("scan_d0_seg", sseg_indicator, 8'h8E);
        check("scan_d0_dig", digits, 4'hE);
      end
      if (k == 3) check("scan_d0_last_seg", sseg_indicator, 8'h8E);
      if (k == 4) check("scan_d1_guard", digits, 4'hF);
      if (k == 5) begin
        check("scan_d1_seg", sseg_indicator, 8'h88);
        check("scan_d1_dig", digits, 4'hD);
      end
      if (k == 9) begin
        check("scan_d2_seg", sseg_indicator, 8'hA4);
        check("scan_d2_dig", digits, 4'hB);
      end
      if (k == 13) begin
        check("scan_d3_seg", sseg_indicator, 8'hF9);
        check("scan_d3_dig", digits, 4'h7);
        check("scan_fd_low", frame_done, 1'b0);
      end
      if (k == 14) check("scan_fd_high", frame_done, 1'b1);
      if (k == 15) check("scan_fd_after", frame_done, 1'b0);
    end
    repeat (15) tick();
    check("scan_fd_period", frame_done, 1'b1);

    // Tear-free update: two loads within one frame, last wins.
    repeat (3) tick();
    value = 16'h1111; load = 1'b1; tick(); load = 1'b0;
    repeat (4) tick();
    value = 16'h2222; load = 1'b1; tick(); load = 1'b0;
    repeat (40) tick();

    // Load coinciding with the wrap goes straight to display.
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (frame_done) seen = 1;
    end
    check("wait_wrap", {31'b0, seen}, 32'd1);
    value = 16'h00C0; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (2) tick();
    check("wrapload_d0_seg", sseg_indicator, 8'hC0);
    check("wrapload_d0_dig", digits, 4'hE);
    repeat (4) tick();
    check("wrapload_d1_seg", sseg_indicator, 8'hC6);

    // Enable dropped at digit 2.
    wait_digit(4'hB, "wait_idx2_en");
    enable = 1'b0;
    tick();
    check("disable_seg", sseg_indicator, 8'hFF);
    check("disable_dig", digits, 4'hF);
    enable = 1'b1;
    tick();
    check("reenable_guard", digits, 4'hF);
    tick();
    check("reenable_d0", digits, 4'hE);
    check("reenable_d0_seg", sseg_indicator, 8'hC0);

    // Reset at digit 2 clears the shadow to 0000.
    wait_digit(4'hB, "wait_idx2_rst");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_dig", digits, 4'hF);
    tick();
    check("rst_restart_guard", digits, 4'hF);
    tick();
    check("rst_restart_d0_seg", sseg_indicator, 8'hC0);
    check("rst_restart_d0_dig", digits, 4'hE);
    repeat (20) tick();

    // Small values, exercising leading-zero handling when built with it.
    enable = 1'b0; value = 16'h0005; load = 1'b1;
    tick();
    load = 1'b0; enable = 1'b1;
    repeat (2) tick();
    check("v0005_d0_seg", sseg_indicator, 8'h92);
    repeat (30) tick();
    enable = 1'b0; value = 16'h0000; load = 1'b1;
    tick();
    load = 1'b0; enable = 1'b1;
    repeat (2) tick();
    check("v0000_d0_seg", sseg_indicator, 8'hC0);
    repeat (30) tick();

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      tick();
      dp    = 4'($urandom);
      value = 16'($urandom);
      load  = ($urandom % 10) == 0;
      reset = ($urandom % 400) == 0;
      if (enable) enable = ($urandom % 50) != 0;
      else        enable = ($urandom % 4) == 0;
    end
    tick();
    load = 1'b0; reset = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
